// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, drives a 1-cycle-latency instruction ROM,
// absorbs decode stalls and branch/jump redirects, and feeds the IF/ID register.
module fetch_sequencer #(
  parameter int width_B = 32,
  parameter int Addr_B  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [width_B-1:0] branch_target,
  input  logic               jump_taken,
  input  logic [25:0]        jump_index,
  output logic [Addr_B-1:0]  rom_addr,
  input  logic [width_B-1:0] rom_data,
  output logic [width_B-1:0] if_id_instr,
  output logic [width_B-1:0] if_id_pc_plus1,
  output logic               if_id_valid,
  output logic [width_B-1:0] pc_debug,
  output logic [15:0]        flush_count
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_e;

  state_e             state_q;
  logic [width_B-1:0] pc_q, pc_d;
  logic [width_B-1:0] infl_pc_q, infl_pc_d;
  logic               infl_valid_q, infl_valid_d;
  logic [width_B-1:0] if_instr_q, if_instr_d;
  logic [width_B-1:0] if_pc1_q, if_pc1_d;
  logic               if_valid_q, if_valid_d;
  logic [15:0]        flush_q, flush_d;

  logic               redirect;
  logic [width_B-1:0] jump_target;
  logic [width_B-1:0] target;

  assign redirect    = branch_taken | jump_taken;
  assign jump_target = {if_pc1_q[width_B-1:26], jump_index};
  assign target      = branch_taken ? branch_target : jump_target;

  // During a stall the in-flight address is replayed so rom_data stays valid for it.
  assign rom_addr = redirect ? target[Addr_B-1:0]
                  : stall    ? infl_pc_q[Addr_B-1:0]
                  :            pc_q[Addr_B-1:0];

  always_comb begin
    // NOTE: every _d gets a default up front so no path can infer a latch.
    pc_d         = pc_q;
    infl_pc_d    = infl_pc_q;
    infl_valid_d = infl_valid_q;
    if_instr_d   = if_instr_q;
    if_pc1_d     = if_pc1_q;
    if_valid_d   = if_valid_q;
    flush_d      = flush_q;

    if (redirect) begin
      if_instr_d   = '0;
      if_pc1_d     = '0;
      if_valid_d   = 1'b0;
      infl_pc_d    = target;
      infl_valid_d = 1'b1;
      pc_d         = target + 1'b1;
      if (flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
    end else if (!stall) begin
      // An empty in-flight slot becomes a bubble, which always carries a nop.
      if_instr_d   = infl_valid_q ? rom_data : '0;
      if_pc1_d     = infl_valid_q ? infl_pc_q + 1'b1 : '0;
      if_valid_d   = infl_valid_q;
      infl_pc_d    = pc_q;
      infl_valid_d = 1'b1;
      pc_d         = pc_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= '0;
      infl_pc_q    <= '0;
      infl_valid_q <= 1'b0;
      if_instr_q   <= '0;
      if_pc1_q     <= '0;
      if_valid_q   <= 1'b0;
      flush_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      infl_pc_q    <= infl_pc_d;
      infl_valid_q <= infl_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc1_q     <= if_pc1_d;
      if_valid_q   <= if_valid_d;
      flush_q      <= flush_d;
      case (state_q)
        BOOT:    state_q <= (stall && !redirect) ? STALL : RUN;
        RUN:     if (stall && !redirect) state_q <= STALL;
        STALL:   if (!stall || redirect) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

  assign if_id_instr    = if_instr_q;
  assign if_id_pc_plus1 = if_pc1_q;
  assign if_id_valid    = if_valid_q;
  assign pc_debug       = pc_q;
  assign flush_count    = flush_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural 1-cycle ROM holding
// mem[i] = 0x1000_0000 + i.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_taken;
  logic [25:0] jump_index;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic [31:0] pc_debug;
  logic [15:0] flush_count;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.width_B(32), .Addr_B(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump_taken     (jump_taken),
    .jump_index     (jump_index),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .pc_debug       (pc_debug),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [9:0] a);
    return 32'h1000_0000 + {22'd0, a};
  endfunction

  always @(posedge clk) rom_data <= mem(rom_addr);

  function automatic logic [64:0] ifid_exp(input logic v, input logic [31:0] i,
                                           input logic [31:0] p);
    return {v, i, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect();
    branch_taken = 1'b0;
    jump_taken   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; clear_redirect();
    branch_target = '0; jump_index = '0;
    tick(); tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== 65'd0) begin
      failures++; $display("FAIL reset_ifid got=%h exp=0", {if_id_valid, if_id_instr, if_id_pc_plus1});
    end
    checks++;
    if ({pc_debug, flush_count, rom_addr} !== 58'd0) begin
      failures++; $display("FAIL reset_state pc=%h flush=%h rom_addr=%h exp all 0", pc_debug, flush_count, rom_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_startup();
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== 65'd0) begin
      failures++; $display("FAIL startup_e1 got=%h exp=bubble", {if_id_valid, if_id_instr, if_id_pc_plus1});
    end
    for (int k = 2; k <= 6; k++) begin
      tick();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== ifid_exp(1'b1, mem(10'(k - 2)), 32'(k - 1))) begin
        failures++; $display("FAIL startup_e%0d got=%h exp=%h", k, {if_id_valid, if_id_instr, if_id_pc_plus1},
                             ifid_exp(1'b1, mem(10'(k - 2)), 32'(k - 1)));
      end
    end
    checks++;
    if (pc_debug !== 32'd6 || flush_count !== 16'd0) begin
      failures++; $display("FAIL startup_pc pc=%h flush=%h exp 6/0", pc_debug, flush_count);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++;
    if (rom_addr !== 10'd5) begin
      failures++; $display("FAIL stall_rom_addr got=%h exp=5", rom_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc_plus1, pc_debug} !== {ifid_exp(1'b1, mem(10'd4), 32'd5), 32'd6}) begin
        failures++; $display("FAIL stall_hold%0d ifid=%h pc=%h exp mem4/5 pc=6", k,
                             {if_id_valid, if_id_instr, if_id_pc_plus1}, pc_debug);
      end
    end
    stall = 1'b0;
    for (int k = 5; k <= 6; k++) begin
      tick();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== ifid_exp(1'b1, mem(10'(k)), 32'(k + 1))) begin
        failures++; $display("FAIL stall_release%0d got=%h exp=%h", k, {if_id_valid, if_id_instr, if_id_pc_plus1},
                             ifid_exp(1'b1, mem(10'(k)), 32'(k + 1)));
      end
    end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 32'h40;
    #1;
    checks++;
    if (rom_addr !== 10'h40) begin
      failures++; $display("FAIL branch_rom_addr got=%h exp=40", rom_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1, pc_debug, flush_count} !== {65'd0, 32'h41, 16'd1}) begin
      failures++; $display("FAIL branch_bubble ifid=%h pc=%h flush=%h exp 0/41/1",
                           {if_id_valid, if_id_instr, if_id_pc_plus1}, pc_debug, flush_count);
    end
    clear_redirect();
    for (int k = 'h40; k <= 'h41; k++) begin
      tick();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== ifid_exp(1'b1, mem(10'(k)), 32'(k + 1))) begin
        failures++; $display("FAIL branch_target_%h got=%h exp=%h", k, {if_id_valid, if_id_instr, if_id_pc_plus1},
                             ifid_exp(1'b1, mem(10'(k)), 32'(k + 1)));
      end
    end
  endtask

  task automatic test_priority_and_jump();
    branch_taken = 1'b1; branch_target = 32'h20; jump_taken = 1'b1; jump_index = 26'h30;
    #1;
    checks++;
    if (rom_addr !== 10'h20) begin
      failures++; $display("FAIL priority_rom_addr got=%h exp=20", rom_addr);
    end
    tick();
    clear_redirect();
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1, flush_count} !== {ifid_exp(1'b1, mem(10'h20), 32'h21), 16'd2}) begin
      failures++; $display("FAIL priority_resume ifid=%h flush=%h exp mem20/21 flush 2",
                           {if_id_valid, if_id_instr, if_id_pc_plus1}, flush_count);
    end
    // Land on an address whose pc_plus1 carries nonzero upper bits for the jump.
    branch_taken = 1'b1; branch_target = 32'h0400_000F;
    tick();
    clear_redirect();
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== ifid_exp(1'b1, mem(10'h00F), 32'h0400_0010)) begin
      failures++; $display("FAIL jump_setup got=%h exp=%h", {if_id_valid, if_id_instr, if_id_pc_plus1},
                           ifid_exp(1'b1, mem(10'h00F), 32'h0400_0010));
    end
    jump_taken = 1'b1; jump_index = 26'h100;
    #1;
    checks++;
    if (rom_addr !== 10'h100) begin
      failures++; $display("FAIL jump_rom_addr got=%h exp=100", rom_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, pc_debug} !== {1'b0, 32'h0400_0101}) begin
      failures++; $display("FAIL jump_bubble valid=%b pc=%h exp 0/04000101", if_id_valid, pc_debug);
    end
    clear_redirect();
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1, flush_count} !== {ifid_exp(1'b1, mem(10'h100), 32'h0400_0101), 16'd4}) begin
      failures++; $display("FAIL jump_resume ifid=%h flush=%h exp mem100/04000101 flush 4",
                           {if_id_valid, if_id_instr, if_id_pc_plus1}, flush_count);
    end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    #1;
    checks++;
    if (rom_addr !== 10'h80) begin
      failures++; $display("FAIL stall_redir_rom_addr got=%h exp=80", rom_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1, pc_debug, flush_count} !== {65'd0, 32'h81, 16'd5}) begin
      failures++; $display("FAIL stall_redir_bubble ifid=%h pc=%h flush=%h exp 0/81/5",
                           {if_id_valid, if_id_instr, if_id_pc_plus1}, pc_debug, flush_count);
    end
    clear_redirect();
    tick();
    checks++;
    if ({if_id_valid, pc_debug, rom_addr} !== {1'b0, 32'h81, 10'h80}) begin
      failures++; $display("FAIL stall_after_redir valid=%b pc=%h rom_addr=%h exp 0/81/80", if_id_valid, pc_debug, rom_addr);
    end
    stall = 1'b0;
    for (int k = 'h80; k <= 'h81; k++) begin
      tick();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== ifid_exp(1'b1, mem(10'(k)), 32'(k + 1))) begin
        failures++; $display("FAIL stall_redir_seq_%h got=%h exp=%h", k, {if_id_valid, if_id_instr, if_id_pc_plus1},
                             ifid_exp(1'b1, mem(10'(k)), 32'(k + 1)));
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1, pc_debug, flush_count, rom_addr} !== 123'd0) begin
      failures++; $display("FAIL reset_mid ifid=%h pc=%h flush=%h rom_addr=%h exp all 0",
                           {if_id_valid, if_id_instr, if_id_pc_plus1}, pc_debug, flush_count, rom_addr);
    end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({if_id_valid, if_id_instr, pc_debug} !== 65'd0) begin
      failures++; $display("FAIL boot_stall valid=%b instr=%h pc=%h exp 0/0/0", if_id_valid, if_id_instr, pc_debug);
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({if_id_valid, pc_debug} !== {1'b0, 32'd1}) begin
      failures++; $display("FAIL boot_release valid=%b pc=%h exp 0/1", if_id_valid, pc_debug);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== ifid_exp(1'b1, mem(10'd0), 32'd1)) begin
      failures++; $display("FAIL boot_first got=%h exp=%h", {if_id_valid, if_id_instr, if_id_pc_plus1},
                           ifid_exp(1'b1, mem(10'd0), 32'd1));
    end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'h3FE;
    tick();
    clear_redirect();
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== ifid_exp(1'b1, mem(10'h3FE), 32'h3FF)) begin
      failures++; $display("FAIL wrap_3fe got=%h exp=%h", {if_id_valid, if_id_instr, if_id_pc_plus1},
                           ifid_exp(1'b1, mem(10'h3FE), 32'h3FF));
    end
    checks++;
    if ({rom_addr, pc_debug} !== {10'h000, 32'h400}) begin
      failures++; $display("FAIL wrap_rom_addr rom_addr=%h pc=%h exp 000/400", rom_addr, pc_debug);
    end
    tick(); tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1} !== ifid_exp(1'b1, mem(10'h000), 32'h401)) begin
      failures++; $display("FAIL wrap_fetch0 got=%h exp=%h", {if_id_valid, if_id_instr, if_id_pc_plus1},
                           ifid_exp(1'b1, mem(10'h000), 32'h401));
    end
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    clear_redirect();
    #1;
    checks++;
    if ({pc_debug, rom_addr} !== 42'd0) begin
      failures++; $display("FAIL wrap_pc32 pc=%h rom_addr=%h exp 0/0", pc_debug, rom_addr);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1, flush_count} !== {ifid_exp(1'b1, mem(10'h3FF), 32'd0), 16'd2}) begin
      failures++; $display("FAIL wrap_pc_plus1 ifid=%h flush=%h exp mem3ff/0 flush 2",
                           {if_id_valid, if_id_instr, if_id_pc_plus1}, flush_count);
    end
  endtask

  task automatic test_flush_saturate();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h10;
    repeat (65534) tick();
    checks++;
    if (flush_count !== 16'hFFFE) begin
      failures++; $display("FAIL sat_fffe got=%h exp=fffe", flush_count);
    end
    tick();
    checks++;
    if (flush_count !== 16'hFFFF) begin
      failures++; $display("FAIL sat_ffff got=%h exp=ffff", flush_count);
    end
    repeat (3) tick();
    checks++;
    if ({flush_count, if_id_valid} !== {16'hFFFF, 1'b0}) begin
      failures++; $display("FAIL sat_hold flush=%h valid=%b exp ffff/0", flush_count, if_id_valid);
    end
    clear_redirect();
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc_plus1, flush_count} !== {ifid_exp(1'b1, mem(10'h10), 32'h11), 16'hFFFF}) begin
      failures++; $display("FAIL sat_resume ifid=%h flush=%h exp mem10/11 flush ffff",
                           {if_id_valid, if_id_instr, if_id_pc_plus1}, flush_count);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_branch();
    test_priority_and_jump();
    test_stall_redirect();
    test_reset_mid_stall();
    test_wrap();
    test_flush_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that owns the program counter and drives the synchronous instruction ROM (1-cycle read latency, word-addressed, PC advances by 1). It handles ROM latency, decode stalls and branch/jump redirects, and presents an IF/ID pipeline register with a valid bit to the decode stage. It replaces the free-running PC and next-PC mux logic in the fetch block.

## Interface
- width_B, 32, data/PC width
- Addr_B, 10, ROM address width
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- stall  in  1  hold fetch and IF/ID (from hazard unit)
- branch_taken  in  1  redirect to branch_target
- branch_target  in  width_B  absolute word address (PC+1+offset, computed downstream)
- jump_taken  in  1  redirect to jump target
- jump_index  in  26  jump field of the jump instruction
- rom_addr  out  Addr_B  ROM address (to addra)
- rom_data  in  width_B  ROM output (douta), holds mem[address presented last cycle]
- if_id_instr  out  width_B  registered instruction
- if_id_pc_plus1  out  width_B  registered address of that instruction + 1
- if_id_valid  out  1  0 = bubble
- pc_debug  out  width_B  current pc register
- flush_count  out  16  saturating count of redirects taken

## Operation
- State: pc (next address to issue), infl_pc/infl_valid (address issued last cycle; rom_data belongs to it), IF/ID register, FSM, flush_count.
- FSM states: BOOT (first cycle after reset), RUN, STALL. reset -> BOOT; BOOT -> RUN (or STALL if stall); RUN -> STALL when stall and no redirect; STALL -> RUN when stall=0 or redirect.
- Redirect = branch_taken | jump_taken; branch has priority when both high. Target: branch_target, or {if_id_pc_plus1[31:26], jump_index}.
- rom_addr (combinational, low Addr_B bits): redirect ? target : stall ? infl_pc : pc. Replaying infl_pc during stall keeps rom_data stable.
- Normal advance (no stall, no redirect): IF/ID <= {rom_data, infl_pc+1, infl_valid}; infl <= {1, pc}; pc <= pc+1.
- Stall (no redirect): pc, infl, IF/ID all hold.
- Redirect (overrides stall): IF/ID <= bubble (valid=0, instr=0, pc_plus1=0); infl <= {1, target}; pc <= target+1; flush_count += 1, saturating at 0xFFFF.
- Bubble always carries instr=0 (nop).
- Arithmetic: pc and infl_pc are width_B wide, +1 wraps 0xFFFFFFFF -> 0; rom_addr truncates, so fetch wraps at 2^Addr_B (1023 -> 0).

## Timing
- Reset values: pc=0, infl_pc=0, infl_valid=0, IF/ID all 0 (valid=0), flush_count=0, FSM=BOOT, rom_addr=0, pc_debug=0.
- Reset asserted mid-operation: all state returns to reset values on the next edge regardless of stall/redirect.
- Startup: after reset release, edge 1 issues address 0 (IF/ID bubble), edge 2 loads mem[0] into IF/ID with pc_plus1=1, valid=1. One instruction per cycle thereafter.
- Redirect penalty: exactly one bubble. Redirect sampled at edge N -> IF/ID bubble after N; mem[target] in IF/ID after N+1 with pc_plus1=target+1.
- Stall: zero latency; IF/ID unchanged at every edge with stall=1; on release, next edge loads the instruction that was pending, without loss or duplication.
- Stall during BOOT: infl_valid stays 0; no spurious valid.
- Redirect in the same cycle as stall: redirect taken, stall ignored for that edge.

## Test plan
- Reset, ROM mem[i]=0x1000_0000+i, no stall/redirect -> IF/ID valid from edge 2: instr 0x10000000,0x10000001,... with pc_plus1 1,2,...; flush_count=0.
- Stall for 3 cycles while IF/ID holds mem[4] -> IF/ID frozen at mem[4]/5 for 3 edges; next edge mem[5]/6; no skipped or duplicated instruction.
- branch_taken=1, branch_target=0x40 for one cycle -> one bubble, then mem[0x40], pc_plus1=0x41, followed by mem[0x41]; flush_count=1.
- branch_taken and jump_taken together (branch_target=0x20, jump_index=0x30) -> fetch resumes at 0x20; jump with if_id_pc_plus1=0x0400_0010, jump_index=0x100 -> target 0x0400_0100, rom_addr=0x100.
- Stall held plus branch_taken=1 in the same cycle -> redirect taken; sequence resumes at the target. Reset asserted during a stall -> all outputs return to reset values next edge.
- Run to pc=1023 -> rom_addr wraps to 0. Force 0xFFFF redirects -> flush_count stays at 0xFFFF.
